// File: rtl/cnn_dvcon_pkg.sv
// cnn_dvcon_pkg: shared widths, tdata layout offsets and the tap unpacker
// for the 3x3 convolution engine.
//   DATA_W  pixel / weight width
//   TAPS    window elements (fixed at 9, three rows of three)
//   ACC_W   result width (>= 2*DATA_W+4 so the 9-term sum cannot overflow)
//   PROD_W  exact signed width of one unsigned-pixel x signed-weight product
package cnn_dvcon_pkg;
  localparam int DATA_W   = 8;
  localparam int TAPS     = 9;
  localparam int ACC_W    = 20;
  localparam int PROD_W   = 2*DATA_W+1;
  localparam int TDATA_W  = 2*TAPS*DATA_W;
  localparam int KER_BASE = TAPS*DATA_W;   // 72
  localparam int IMG_BASE = 0;
  localparam int STAGES   = 3;

  typedef struct packed {
    logic [DATA_W-1:0] img;   // unsigned pixel
    logic [DATA_W-1:0] ker;   // signed weight
  } tap_t;

  // Tap 0 sits in the most significant byte of each half.
  function automatic tap_t unpack_tap(input logic [TDATA_W-1:0] d, input int i);
    tap_t t;
    t.ker = d[KER_BASE + (TAPS-1-i)*DATA_W +: DATA_W];
    t.img = d[IMG_BASE + (TAPS-1-i)*DATA_W +: DATA_W];
    return t;
  endfunction
endpackage

// File: rtl/cnn_dvcon_mac3.sv
// cnn_dvcon_mac3: one 3-tap row of the window. Stage 1 registers the three
// exact products, stage 2 registers their sign-extended sum.
//   aclk, aresetn  clock / async active-low reset
//   en             shared pipeline enable
//   img, ker       three pixels (unsigned) and weights (signed)
//   row_sum        registered signed row sum, ACC_W bits
module cnn_dvcon_mac3
  import cnn_dvcon_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   en,
  input  logic [2:0][DATA_W-1:0] img,
  input  logic [2:0][DATA_W-1:0] ker,
  output logic [ACC_W-1:0]       row_sum
);
  logic signed [PROD_W-1:0] prod_d [3];
  logic signed [PROD_W-1:0] prod_q [3];

  // Pixel is zero-extended, weight sign-extended; 17 bits hold the product exactly.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      prod_d[j] = PROD_W'($signed({1'b0, img[j]})) * PROD_W'($signed(ker[j]));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int j = 0; j < 3; j++) prod_q[j] <= '0;
      row_sum <= '0;
    end else if (en) begin
      prod_q  <= prod_d;
      row_sum <= ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]) + ACC_W'(prod_q[2]);
    end
  end
endmodule

// File: rtl/cnn_dvcon.sv
// cnn_dvcon: 3x3 convolution engine. Each input beat carries a 3x3 window and
// kernel; one signed dot product leaves per beat, 3 stages, 1 beat/clock.
//   aclk, aresetn     clock / async active-low reset
//   s_axis_*          input stream, tdata = {ker0..ker8, img0..img8}
//   m_axis_*          output stream, tdata = signed ACC_W result
module cnn_dvcon
  import cnn_dvcon_pkg::*;
(
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [TDATA_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [ACC_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);
  logic                         en;
  logic [STAGES:1]              vld_pipe;
  logic [2:0][2:0][DATA_W-1:0]  img_r, ker_r;
  logic [2:0][ACC_W-1:0]        row_sum;

  // Whole pipeline stalls only when a result is held unaccepted.
  assign en            = !(m_axis_tvalid && !m_axis_tready);
  assign s_axis_tready = en;
  assign m_axis_tvalid = vld_pipe[STAGES];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        img_r[r][j] = unpack_tap(s_axis_tdata, 3*r+j).img;
        ker_r[r][j] = unpack_tap(s_axis_tdata, 3*r+j).ker;
      end
    end
  end

  cnn_dvcon_mac3 u_row [2:0] (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .img     (img_r),
    .ker     (ker_r),
    .row_sum (row_sum)
  );

  // Valid shifts with the data; an unaccepted cycle inserts a 0 bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe     <= '0;
      m_axis_tdata <= '0;
    end else if (en) begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], s_axis_tvalid};
      m_axis_tdata <= row_sum[0] + row_sum[1] + row_sum[2];
    end
  end
endmodule

// File: tb/tb_cnn_dvcon.sv
module tb_cnn_dvcon;
  logic         aclk = 1'b0;
  logic         aresetn;
  logic [143:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [19:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  int nvec = 0;
  int nerr = 0;
  int img [9];
  int ker [9];

  always #5 aclk = ~aclk;

  cnn_dvcon dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] mk(input int im [9], input int kr [9]);
    logic [143:0] d;
    logic [31:0]  a, b;
    d = '0;
    for (int i = 0; i < 9; i++) begin
      a = im[i];
      b = kr[i];
      d[143-8*i -: 8] = b[7:0];
      d[71-8*i -: 8]  = a[7:0];
    end
    return d;
  endfunction

  // Identity kernel beat: result equals the centre pixel v.
  function automatic logic [143:0] idb(input int v);
    int im [9];
    int kr [9];
    for (int i = 0; i < 9; i++) begin im[i] = 7; kr[i] = 0; end
    im[4] = v;
    kr[4] = 1;
    return mk(im, kr);
  endfunction

  task automatic single(input logic [143:0] d, input logic [19:0] e, input string tag);
    @(negedge aclk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {144{1'b1}};
    chk({tag, "_v_k0"}, m_axis_tvalid, 0);
    @(posedge aclk);
    @(negedge aclk);
    chk({tag, "_v_k1"}, m_axis_tvalid, 0);
    @(posedge aclk);
    @(negedge aclk);
    chk({tag, "_v_k2"}, m_axis_tvalid, 1);
    chk({tag, "_data"}, m_axis_tdata, e);
    @(posedge aclk);
    @(negedge aclk);
    chk({tag, "_bubble"}, m_axis_tvalid, 0);
  endtask

  initial begin
    logic [19:0] expq [$];
    int got, first;

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    chk("rst_sready", s_axis_tready, 1);
    aresetn = 1'b1;

    // Directed window
    img = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    ker = '{1, 0, -1, 1, 0, -1, 1, 0, -1};
    single(mk(img, ker), 20'hFFFC4, "dir");

    // Extremes
    img = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    ker = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    single(mk(img, ker), 20'hB8480, "min");
    ker = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
    single(mk(img, ker), 20'h47289, "max");

    // Identity kernel, positive and negated
    img = '{0, 0, 0, 0, 200, 0, 0, 0, 0};
    ker = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    single(mk(img, ker), 20'd200, "id_pos");
    ker[4] = -1;
    single(mk(img, ker), 20'hFFF38, "id_neg");

    // Back-to-back, four beats, no backpressure
    expq = '{20'd11, 20'd22, 20'd33, 20'd44};
    got = 0;
    first = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        if (first < 0) first = c;
        chk("b2b_data", m_axis_tdata, (got < 4) ? expq[got] : 20'hDEAD0);
        chk("b2b_cycle", c, first + got);
        got++;
      end
      if (c < 4) begin
        chk("b2b_sready", s_axis_tready, 1);
        s_axis_tdata  = idb(11 * (c + 1));
        s_axis_tvalid = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      @(posedge aclk);
    end
    chk("b2b_count", got, 4);

    // Backpressure: fill pipeline with 101..103 while downstream stalls
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      m_axis_tready = 1'b0;
      s_axis_tdata  = idb(101 + c);
      s_axis_tvalid = 1'b1;
      @(posedge aclk);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      s_axis_tdata = idb(104);
      chk("bp_sready", s_axis_tready, 0);
      chk("bp_mvalid", m_axis_tvalid, 1);
      chk("bp_hold", m_axis_tdata, 20'd101);
      @(posedge aclk);
    end
    expq = '{20'd101, 20'd102, 20'd103, 20'd104};
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      m_axis_tready = 1'b1;
      if (m_axis_tvalid) begin
        chk("bp_drain", m_axis_tdata, (got < 4) ? expq[got] : 20'hDEAD0);
        got++;
      end
      if (c != 0) s_axis_tvalid = 1'b0;
      @(posedge aclk);
    end
    chk("bp_count", got, 4);

    // Reset with one result at the output and two beats behind it
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      s_axis_tdata  = idb(50 + c);
      s_axis_tvalid = 1'b1;
      @(posedge aclk);
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk("pre_rst_mvalid", m_axis_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_mvalid", m_axis_tvalid, 0);
    chk("mid_rst_mdata", m_axis_tdata, 0);
    chk("mid_rst_sready", s_axis_tready, 1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (m_axis_tvalid) got++;
    end
    chk("post_rst_stale", got, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cnn_dvcon.md
Name: cnn_dvcon

Overview:
- 3x3 convolution engine: one AXI4-Stream beat carries a full 3x3 image window and a 3x3 kernel.
- Produces one signed dot-product result per beat on an output AXI4-Stream.
- Sits between the SoC stream DMA/interconnect and the result sink of the CNN accelerator.
- Fully pipelined: sustains one beat per clock with backpressure support.

Parameters:
- DATA_W, 8, width of each image pixel and each kernel weight.
- ACC_W, 20, width of the result. Must be at least 2*DATA_W+4.
- TAPS, 9, number of window elements. Fixed at 9; other values are unsupported.

Ports:
- aclk  in  1  single clock; all logic is on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low. Deassertion is synchronous to aclk.
- s_axis_tdata  in  144  packed window. Layout, MSB first: ker0..ker8 in [143:72], img0..img8 in [71:0]. ker0=[143:136], ker8=[79:72], img0=[71:64], img8=[7:0].
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid&&tready.
- m_axis_tdata  out  ACC_W  result, signed two's complement.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Arithmetic
  - Pixels img[i] are unsigned 8-bit (0..255).
  - Weights ker[i] are signed 8-bit two's complement (8'hFF = -1).
  - result = sum over i=0..8 of img[i]*ker[i].
  - Each product is exact signed 17-bit (zero-extend pixel, sign-extend weight); the sum is accumulated sign-extended to ACC_W.
  - Range is -293760..+291465. It fits in 20-bit signed, so no overflow or saturation logic is needed.
- Pipeline: 3 register stages sharing one enable.
  - S1: 9 products registered, plus valid v1.
  - S2: three row sums registered (taps 0-2, 3-5, 6-8), plus v2.
  - S3: final sum registered into m_axis_tdata, with m_axis_tvalid.
- Enable: en = !(m_axis_tvalid && !m_axis_tready). s_axis_tready = en, combinational from m_axis_tready.
- Latency: a beat accepted at rising edge k gives m_axis_tvalid=1 with its result after edge k+2.
- Throughput: with m_axis_tready held high, one result per clock and no bubbles are inserted.
- Bubbles: when en=1 and no input beat is accepted, a 0 valid bit propagates down the pipeline.
- Backpressure
  - While m_axis_tvalid=1 and m_axis_tready=0, all stages hold.
  - m_axis_tdata and m_axis_tvalid stay stable, and s_axis_tready=0.
- Simultaneous output handshake and input acceptance in the same cycle is allowed (en=1).
- Reset (aresetn=0, at any time including mid-operation)
  - All valid bits and m_axis_tvalid clear to 0 immediately.
  - All data registers and m_axis_tdata clear to 0.
  - In-flight beats are discarded and no partial results are emitted.
  - s_axis_tready follows the en equation, so it is 1 in reset.
- Input tdata is ignored when s_axis_tvalid=0. No X propagates into valid logic.

Decomposition:
- Package cnn_dvcon_pkg holds:
  - constants DATA_W, TAPS, ACC_W, PROD_W=2*DATA_W+1;
  - localparams for the tdata bit offsets (KER_BASE=72, IMG_BASE=0);
  - a function that unpacks tap i.
- One natural sub-module, cnn_dvcon_mac3: a 3-tap signed-product-and-sum row slice, instantiated 3 times. The top level holds valid tracking and the final adder.

Test Plan:
- Directed beat: img=[10,20,30,40,50,60,70,80,90], ker=[1,0,-1] per row.
  - Result -60 = 20'hFFFC4.
  - m_axis_tvalid rises 2 edges after the acceptance edge.
- Extremes
  - All img=255, all ker=-128 (8'h80) -> -293760 = 20'hB8480.
  - All img=255, all ker=127 -> 291465 = 20'h47289.
- Identity kernel: ker4=1, others 0, img4=200 -> 200. Then ker4=-1 -> 20'hFFF38.
- Back-to-back 4 beats, m_axis_tready=1: results appear on 4 consecutive cycles in order, and s_axis_tready stays 1.
- Backpressure: hold m_axis_tready=0 for 5 cycles with the pipeline full.
  - s_axis_tready=0 and output stable.
  - On release, results drain in order with none lost or duplicated.
- Reset mid-flight: assert aresetn=0 with 2 beats in flight.
  - m_axis_tvalid=0 and m_axis_tdata=0 immediately.
  - No stale result appears after deassertion.
